rf_scan_reader: RTL and testbench

- Streams a contiguous window of the 32x32 register file out over a valid/ready port, one word per cycle at full throughput.
- Drives one RF asynchronous read port: address out, data in the same cycle.
- It is the read-side counterpart of the ALU write-back sequencer that fills the register file. It is used for result dump, checking and debug readout.

---
 rtl/rf_pkg.sv | 16 +
 rtl/rf_scan_outreg.sv | 40 ++++
 rtl/rf_scan_reader.sv | 115 +++++++++++
 tb/tb_rf_scan_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the RF scan/readout blocks.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

  typedef enum logic {
    IDLE,
    RUN
  } scan_state_t;

endpackage

// File: rtl/rf_scan_outreg.sv
// Output stage of the RF scan reader: one registered beat with load/hold/clear control.
module rf_scan_outreg
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          clear,
  input  logic [DW-1:0] load_data,
  input  logic [AW-1:0] load_addr,
  input  logic          load_last,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_addr,
  output logic          m_last
);

  // A load takes priority over a clear so an accepted beat is replaced
  // by the next one in the same cycle, keeping full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_addr  <= '0;
      m_last  <= 1'b0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
      m_addr  <= load_addr;
      m_last  <= load_last;
    end else if (clear) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_scan_reader.sv
// Streams a window of the register file out over a valid/ready port.
// Optional running checksum output enabled by defining RF_SCAN_CHECKSUM_EN.
module rf_scan_reader
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [AW-1:0] m_addr,
  output logic          m_last
`ifdef RF_SCAN_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  localparam int          DEPTH     = 2 ** AW;
  localparam logic [AW:0] MAX_COUNT = (AW + 1)'(DEPTH);

  scan_state_t   state;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fetch_left;
  logic [AW:0]   clamped_count;
  logic          load;
  logic          beat_taken;
  logic          load_last;

  assign clamped_count = (count > MAX_COUNT) ? MAX_COUNT : count;
  assign load          = (state == RUN) && (fetch_left != '0) && (!m_valid || m_ready);
  assign beat_taken    = m_valid && m_ready;
  assign load_last     = (fetch_left == (AW + 1)'(1));
  assign rf_raddr      = rd_ptr;

  // The scan ends on the handshake of the last beat, not on the last fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rd_ptr     <= '0;
      fetch_left <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              rd_ptr     <= base_addr;
              fetch_left <= clamped_count;
              busy       <= 1'b1;
              state      <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load) begin
            rd_ptr     <= rd_ptr + 1'b1;
            fetch_left <= fetch_left - 1'b1;
          end
          if (beat_taken && m_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rf_scan_outreg #(
    .AW(AW),
    .DW(DW)
  ) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .clear    (beat_taken),
    .load_data(rf_rdata),
    .load_addr(rd_ptr),
    .load_last(load_last),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_addr   (m_addr),
    .m_last   (m_last)
  );

`ifdef RF_SCAN_CHECKSUM_EN
  // Sum of accepted beats; the last beat lands on the same edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (beat_taken) begin
      checksum <= checksum + m_data;
    end
  end
`endif

endmodule

// File: tb/tb_rf_scan_reader.sv
// Directed, table-driven testbench for rf_scan_reader with a behavioural register file.
module tb_rf_scan_reader;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic [4:0]  m_addr;
  logic        m_last;
`ifdef RF_SCAN_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  rf_scan_reader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .rf_raddr (rf_raddr),
    .rf_rdata (rf_rdata),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_addr   (m_addr),
    .m_last   (m_last)
`ifdef RF_SCAN_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  typedef struct {
    logic [4:0] base;
    logic [5:0] count;
    logic [5:0] ready_pat;
    int         pat_len;
    int         exp_beats;
    int         exp_done_cycle;
    int         inj_cycle;
  } scan_vec_t;

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic [5:0] c);
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic preloadTriple();
    for (int i = 0; i < 32; i++) rf[i] = 32'(i * 3);
  endtask

  // Runs one scan, driving m_ready from the vector pattern and checking every beat.
  task automatic runVector(input scan_vec_t v, input int idx);
    int          beats;
    int          done_cycle;
    int          ready_idx;
    logic        stalled;
    logic [4:0]  hold_addr;
    logic [31:0] hold_data;
    logic        hold_last;
    logic [4:0]  exp_addr;
    beats      = 0;
    done_cycle = -1;
    ready_idx  = 0;
    stalled    = 1'b0;
    hold_addr  = '0;
    hold_data  = '0;
    hold_last  = 1'b0;
    m_ready    = 1'b1;
    applyStimulus(v.base, v.count);
    checkOutput($sformatf("v%0d busy_after_start", idx), 32'(busy), 32'(v.exp_beats != 0));
    checkOutput($sformatf("v%0d no_valid_after_start", idx), 32'(m_valid), 32'd0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (stalled) begin
        checkOutput($sformatf("v%0d stall_valid", idx), 32'(m_valid), 32'd1);
        checkOutput($sformatf("v%0d stall_addr", idx), 32'(m_addr), 32'(hold_addr));
        checkOutput($sformatf("v%0d stall_data", idx), m_data, hold_data);
        checkOutput($sformatf("v%0d stall_last", idx), 32'(m_last), 32'(hold_last));
      end
      if (done) begin
        done_cycle = cyc;
        break;
      end
      start = (cyc == v.inj_cycle);
      if (cyc == v.inj_cycle) begin
        base_addr = 5'd20;
        count     = 6'd2;
      end
      m_ready = (m_valid && ready_idx < v.pat_len) ? v.ready_pat[ready_idx] : 1'b1;
      if (m_valid) ready_idx++;
      stalled = m_valid && !m_ready;
      if (m_valid && m_ready) begin
        exp_addr = v.base + 5'(beats);
        checkOutput($sformatf("v%0d beat%0d addr", idx, beats), 32'(m_addr), 32'(exp_addr));
        checkOutput($sformatf("v%0d beat%0d data", idx, beats), m_data, 32'(exp_addr) * 3);
        checkOutput($sformatf("v%0d beat%0d last", idx, beats), 32'(m_last),
                    32'(beats == v.exp_beats - 1));
        beats++;
      end else if (stalled) begin
        hold_addr = m_addr;
        hold_data = m_data;
        hold_last = m_last;
      end
      @(posedge clk);
      #1;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    checkOutput($sformatf("v%0d beat_count", idx), 32'(beats), 32'(v.exp_beats));
    checkOutput($sformatf("v%0d done_cycle", idx), 32'(done_cycle), 32'(v.exp_done_cycle));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
    checkOutput($sformatf("v%0d busy_low_after", idx), 32'(busy), 32'd0);
    checkOutput($sformatf("v%0d valid_low_after", idx), 32'(m_valid), 32'd0);
  endtask

  scan_vec_t vecs [7];

  initial begin
    int beats;
    int done_seen;
    int valid_seen;
    int done_at;

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    m_ready   = 1'b1;
    preloadTriple();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset m_last", 32'(m_last), 32'd0);
    checkOutput("reset m_data", m_data, 32'd0);
    checkOutput("reset m_addr", 32'(m_addr), 32'd0);
    checkOutput("reset rf_raddr", 32'(rf_raddr), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // base, count, ready pattern (LSB first), pattern length, beats, done cycle, inject cycle
    vecs[0] = '{5'd0,  6'd32, 6'b000000, 0, 32, 33, -1};
    vecs[1] = '{5'd30, 6'd4,  6'b000000, 0, 4,  5,  -1};
    vecs[2] = '{5'd5,  6'd3,  6'b101001, 6, 3,  7,  -1};
    vecs[3] = '{5'd0,  6'd0,  6'b000000, 0, 0,  0,  -1};
    vecs[4] = '{5'd7,  6'd40, 6'b000000, 0, 32, 33, -1};
    vecs[5] = '{5'd31, 6'd1,  6'b000000, 0, 1,  2,  -1};
    vecs[6] = '{5'd10, 6'd4,  6'b000000, 0, 4,  5,   2};

    for (int i = 0; i < 7; i++) runVector(vecs[i], i);

    // Reset in the middle of a scan, after the second accepted beat.
    applyStimulus(5'd0, 6'd8);
    beats = 0;
    for (int cyc = 0; cyc < 20 && beats < 2; cyc++) begin
      if (m_valid && m_ready) beats++;
      @(posedge clk);
      #1;
    end
    checkOutput("midreset beats_before", 32'(beats), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("midreset m_valid", 32'(m_valid), 32'd0);
    checkOutput("midreset busy", 32'(busy), 32'd0);
    checkOutput("midreset done", 32'(done), 32'd0);
    checkOutput("midreset rf_raddr", 32'(rf_raddr), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    done_seen  = 0;
    valid_seen = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (done) done_seen++;
      if (m_valid) valid_seen++;
      @(posedge clk);
      #1;
    end
    checkOutput("midreset no_done", 32'(done_seen), 32'd0);
    checkOutput("midreset no_beats", 32'(valid_seen), 32'd0);
    runVector('{5'd3, 6'd2, 6'b000000, 0, 2, 3, -1}, 7);

`ifdef RF_SCAN_CHECKSUM_EN
    rf[0] = 32'd1;
    rf[1] = 32'd1;
    rf[2] = 32'd2;
    rf[3] = 32'd3;
    rf[4] = 32'd5;
    applyStimulus(5'd0, 6'd5);
    done_at = -1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (done) begin
        done_at = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("checksum done_seen", 32'(done_at), 32'd6);
    checkOutput("checksum at_done", checksum, 32'd12);
    @(posedge clk);
    #1;
    checkOutput("checksum held", checksum, 32'd12);
    applyStimulus(5'd0, 6'd2);
    checkOutput("checksum cleared_on_start", checksum, 32'd0);
    done_at = -1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (done) begin
        done_at = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("checksum second_done", 32'(done_at), 32'd3);
    checkOutput("checksum second_value", checksum, 32'd2);
    preloadTriple();
`else
    done_at = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
